// File: rtl/fixed_point_add_arbiter_pkg.sv
// Shared types and helpers for the fixed-point add arbiter.
//   state_t  : arbiter FSM states
//   DEF_*    : default build sizes; SIGN_BIT / MAG_W describe the default
//              sign-magnitude layout (sign on top, magnitude below)
//   rr_next  : next round-robin pointer after a grant, with wrap
package fxp_arb_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int SIGN_BIT    = DEF_WIDTH - 1;
  localparam int MAG_W       = DEF_WIDTH - 1;

  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/fixed_point_add_arbiter_if.sv
// Request/response bundle between the lane compute units and the shared
// adder arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : per-requester sign-magnitude operands
//   resp_*              : single tagged result channel (valid/ready)
// master = requester/consumer side, slave = arbiter side.
interface fixed_point_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [ID_W-1:0]               resp_id;
  logic [WIDTH-1:0]              resp_data;
  logic                          resp_ovf;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_ovf
  );
endinterface

// File: rtl/fixed_point_add_arbiter_core.sv
// fxp_sm_add_core: combinational sign-magnitude adder.
//   a, b : operands, bit WIDTH-1 = sign, WIDTH-2:0 = magnitude
//   sum  : sign-magnitude result, zero magnitude always carries a + sign
//   ovf  : carry out of the magnitude field (same-sign adds only)
// The magnitude wraps on overflow; any clamping is left to the caller.
module fxp_sm_add_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  localparam int MW = WIDTH - 1;

  logic          sa, sb, sgn;
  logic [MW-1:0] ma, mb, mag;
  logic [MW:0]   add_full;

  assign sa       = a[WIDTH-1];
  assign sb       = b[WIDTH-1];
  assign ma       = a[MW-1:0];
  assign mb       = b[MW-1:0];
  assign add_full = {1'b0, ma} + {1'b0, mb};

  always_comb begin
    sgn = sa;
    mag = add_full[MW-1:0];
    ovf = 1'b0;
    if (sa == sb) begin
      mag = add_full[MW-1:0];
      ovf = add_full[MW];
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    // Covers cancellation, -0 + -0 and a wrapped overflow landing on zero.
    if (mag == '0) sgn = 1'b0;
    sum = {sgn, mag};
  end
endmodule

// File: rtl/fixed_point_add_arbiter.sv
// fixed_point_add_arbiter: round-robin share of one sign-magnitude adder.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of fixed_point_add_arbiter_if (requests in,
//              tagged result out)
// Flow: IDLE grants one requester and latches its operands, EXEC registers
// the sum, RESP holds the result until resp_ready. One op in flight.
// Build option FXP_ADD_ARB_SAT_EN: clamp the magnitude to all ones on
// overflow instead of wrapping (sign kept, resp_ovf still set).
module fixed_point_add_arbiter
  import fxp_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                      clk,
  input logic                      rst,
  fixed_point_add_arbiter_if.slave bus
);
  localparam int SB = WIDTH - 1;

  state_t          state;
  logic [ID_W-1:0] ptr, op_id, win;
  logic [WIDTH-1:0] op_a, op_b, core_sum, res;
  logic            win_vld, core_ovf;
  logic [ID_W-1:0] idx;
  int              off;

  // Scan from the highest offset down so the lowest offset from ptr is the
  // last assignment and therefore wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    off     = 0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      off = int'(ptr) + k;
      if (off >= NUM_REQ) off = off - NUM_REQ;
      idx = ID_W'(off);
      if (bus.req_valid[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Gated by rst so every output reads 0 while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && win_vld && !rst) bus.req_ready[win] = 1'b1;
  end

  fxp_sm_add_core #(.WIDTH(WIDTH)) u_core (
    .a   (op_a),
    .b   (op_b),
    .sum (core_sum),
    .ovf (core_ovf)
  );

  // Overflow only comes from same-sign adds, so op_a's sign is the sign of
  // the true result even when the core has folded a wrapped zero to +0.
`ifdef FXP_ADD_ARB_SAT_EN
  assign res = core_ovf ? {op_a[SB], {SB{1'b1}}} : core_sum;
`else
  assign res = core_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      op_a           <= '0;
      op_b           <= '0;
      op_id          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= '0;
      bus.resp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          op_a  <= bus.req_a[win];
          op_b  <= bus.req_b[win];
          op_id <= win;
          ptr   <= ID_W'(rr_next(int'(win), NUM_REQ));
          state <= EXEC;
        end
        EXEC: begin
          bus.resp_data  <= res;
          bus.resp_ovf   <= core_ovf;
          bus.resp_id    <= op_id;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_point_add_arbiter.sv
// Directed bench for fixed_point_add_arbiter (4 requesters, 32-bit).
// Expected overflow results follow FXP_ADD_ARB_SAT_EN when it is defined.
module tb_fixed_point_add_arbiter;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fixed_point_add_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) bus ();

  fixed_point_add_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic apply_reset();
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Raise valid for one requester and wait (bounded) for the grant.
  // Returns one time unit after the acceptance edge.
  task automatic issue(input logic [IW-1:0] id, input logic [W-1:0] a,
                       input logic [W-1:0] b, output bit ok);
    ok = 1'b0;
    bus.req_a[id]     = a;
    bus.req_b[id]     = b;
    bus.req_valid[id] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    bus.req_valid[id] = 1'b0;
  endtask

  // Full op with resp_ready high: capture the result one edge after
  // acceptance, then let it be consumed.
  task automatic run_op(input logic [IW-1:0] id, input logic [W-1:0] a,
                        input logic [W-1:0] b, output bit ok,
                        output logic [W-1:0] d, output logic [IW-1:0] rid,
                        output logic ovf, output logic vld);
    bus.resp_ready = 1'b1;
    issue(id, a, b, ok);
    @(posedge clk); #1;
    vld = bus.resp_valid;
    d   = bus.resp_data;
    rid = bus.resp_id;
    ovf = bus.resp_ovf;
    @(posedge clk); #1;
  endtask

  // Next grant index seen on req_ready (bounded), -1 on timeout.
  task automatic next_grant(output int g, output logic [NR-1:0] rdy);
    g   = -1;
    rdy = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        rdy = bus.req_ready;
        for (int i = 0; i < NR; i++) if (rdy[i]) g = i;
        @(posedge clk); #1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = '1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready);
    end
    checks++;
    if ({bus.resp_valid, bus.resp_ovf, bus.resp_id, bus.resp_data} !== '0) begin
      errors++;
      $display("FAIL reset_resp got v=%b o=%b id=%0d d=%h want all 0",
               bus.resp_valid, bus.resp_ovf, bus.resp_id, bus.resp_data);
    end
    apply_reset();
  endtask

  task automatic test_basic_add();
    bit ok;
    bus.resp_ready = 1'b1;
    issue(2'd0, 32'h0001_8000, 32'h8000_8000, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL basic_accept got %b want 1", ok); end
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL basic_exec got v=%b rdy=%b want 0 0000",
                         bus.resp_valid, bus.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_ovf} !==
        {1'b1, 32'h0001_0000, 2'd0, 1'b0}) begin
      errors++; $display("FAIL basic_resp got v=%b d=%h id=%0d o=%b want 1 00010000 0 0",
                         bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain got %b want 0", bus.resp_valid);
    end
  endtask

  task automatic test_cancel_zero();
    bit ok; logic [W-1:0] d; logic [IW-1:0] id; logic o, v;
    run_op(2'd1, 32'h8000_4000, 32'h0000_4000, ok, d, id, o, v);
    checks++;
    if ({ok, v, d, id, o} !== {1'b1, 1'b1, 32'h0, 2'd1, 1'b0}) begin
      errors++; $display("FAIL cancel_zero got ok=%b v=%b d=%h id=%0d o=%b want 1 1 00000000 1 0",
                         ok, v, d, id, o);
    end
    run_op(2'd2, 32'h8000_0000, 32'h8000_0000, ok, d, id, o, v);
    checks++;
    if ({ok, v, d, id, o} !== {1'b1, 1'b1, 32'h0, 2'd2, 1'b0}) begin
      errors++; $display("FAIL neg_zero got ok=%b v=%b d=%h id=%0d o=%b want 1 1 00000000 2 0",
                         ok, v, d, id, o);
    end
    // Differing signs, smaller positive: result takes the negative sign.
    run_op(2'd3, 32'h0000_0005, 32'h8000_0009, ok, d, id, o, v);
    checks++;
    if ({ok, v, d, o} !== {1'b1, 1'b1, 32'h8000_0004, 1'b0}) begin
      errors++; $display("FAIL neg_diff got ok=%b v=%b d=%h o=%b want 1 1 80000004 0",
                         ok, v, d, o);
    end
  endtask

  task automatic test_overflow();
    bit ok; logic [W-1:0] d; logic [IW-1:0] id; logic o, v;
    logic [W-1:0] exp_pos, exp_neg, exp_zero;
`ifdef FXP_ADD_ARB_SAT_EN
    exp_pos  = 32'h7FFF_FFFF;
    exp_neg  = 32'hFFFF_FFFF;
    exp_zero = 32'hFFFF_FFFF;
`else
    exp_pos  = 32'h7FFF_FFFE;
    exp_neg  = 32'hFFFF_FFFE;
    exp_zero = 32'h0000_0000;
`endif
    run_op(2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, ok, d, id, o, v);
    checks++;
    if ({ok, v, d, o} !== {1'b1, 1'b1, exp_pos, 1'b1}) begin
      errors++; $display("FAIL ovf_pos got d=%h o=%b want %h 1", d, o, exp_pos);
    end
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ok, d, id, o, v);
    checks++;
    if ({ok, v, d, o} !== {1'b1, 1'b1, exp_neg, 1'b1}) begin
      errors++; $display("FAIL ovf_neg got d=%h o=%b want %h 1", d, o, exp_neg);
    end
    // Negative overflow wrapping exactly to zero magnitude.
    run_op(2'd2, 32'hC000_0000, 32'hC000_0000, ok, d, id, o, v);
    checks++;
    if ({ok, v, d, o} !== {1'b1, 1'b1, exp_zero, 1'b1}) begin
      errors++; $display("FAIL ovf_wrap_zero got d=%h o=%b want %h 1", d, o, exp_zero);
    end
  endtask

  task automatic test_round_robin();
    int g; logic [NR-1:0] rdy;
    int exp1[5] = '{0, 1, 2, 3, 0};
    int exp2[4] = '{2, 3, 0, 1};
    apply_reset();
    bus.req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      next_grant(g, rdy);
      checks++;
      if (g != exp1[n] || !$onehot(rdy)) begin
        errors++; $display("FAIL rr_all[%0d] got %0d (rdy %b) want %0d", n, g, rdy, exp1[n]);
      end
    end
    bus.req_valid = '0;
    apply_reset();
    bus.req_valid = 4'b0100;
    for (int n = 0; n < 4; n++) begin
      next_grant(g, rdy);
      if (n == 0) bus.req_valid = '1;
      checks++;
      if (g != exp2[n] || !$onehot(rdy)) begin
        errors++; $display("FAIL rr_from2[%0d] got %0d (rdy %b) want %0d", n, g, rdy, exp2[n]);
      end
    end
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_back_pressure();
    bit ok;
    // ptr is 2 here; requester 1 alone wins, leaving ptr at 2.
    bus.resp_ready = 1'b0;
    issue(2'd1, 32'h0000_0003, 32'h0000_0004, ok);
    bus.req_a[3]     = 32'h0000_0010;
    bus.req_b[3]     = 32'h0000_0020;
    bus.req_valid[3] = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({ok, bus.resp_valid, bus.resp_data, bus.resp_id, bus.req_ready} !==
          {1'b1, 1'b1, 32'h0000_0007, 2'd1, 4'b0000}) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d rdy=%b want 1 00000007 1 0000",
                           c, bus.resp_valid, bus.resp_data, bus.resp_id, bus.req_ready);
      end
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got %b want 0", bus.resp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_next_grant got %b want 1000", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_id} !== {1'b1, 32'h0000_0030, 2'd3}) begin
      errors++; $display("FAIL bp_next_resp got v=%b d=%h id=%0d want 1 00000030 3",
                         bus.resp_valid, bus.resp_data, bus.resp_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    bit ok; bit seen;
    bus.resp_ready = 1'b1;
    issue(2'd2, 32'h0000_0100, 32'h0000_0200, ok);
    bus.req_valid = '1;
    rst           = 1'b1;
    #1;
    checks++;
    if ({ok, bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_ovf, bus.req_ready} !==
        {1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 4'b0000}) begin
      errors++; $display("FAIL rst_mid got ok=%b v=%b d=%h id=%0d o=%b rdy=%b want 1 0 0 0 0 0000",
                         ok, bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_ovf, bus.req_ready);
    end
    bus.req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_no_resp got %b want 0", seen);
    end
    bus.req_valid = '1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_ptr got %b want 0001", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    test_reset();
    test_basic_add();
    test_cancel_zero();
    test_overflow();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fixed_point_add_arbiter.md
Name: fixed_point_add_arbiter

Overview:
- Shares one combinational sign-magnitude fixed-point adder between NUM_REQ requesters.
- Arbitration is round-robin. Operands are latched and the sum is registered.
- The response is held on a valid/ready channel tagged with the requester ID.
- Sits between the per-lane compute units and the shared adder datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand width; bit WIDTH-1 = sign, bits WIDTH-2:0 = magnitude
ID_W, $clog2(NUM_REQ), width of requester ID

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester operand-pair valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  operand B, same packing
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_id  out  ID_W  requester that owns the result
resp_data  out  WIDTH  sign-magnitude sum
resp_ovf  out  1  magnitude overflow occurred

Behaviour:
- Reset: clk and rst only; asynchronous, active-high.
  - During reset all outputs are 0, state is IDLE, round-robin pointer is 0, operand registers are 0.
  - Asserting rst mid-operation discards the in-flight op; no response is issued for it.
- State IDLE:
  - Winner = first i with req_valid[i], scanning from ptr upward with wrap (ptr, ptr+1, …, NUM_REQ-1, 0, …).
  - req_ready[winner] is driven combinationally high; all other bits are 0. No valid input means all 0.
  - On the edge of acceptance: latch req_a/req_b/ID of the winner, set ptr = winner+1 (wrap to 0 past NUM_REQ-1), go to EXEC.
- State EXEC:
  - req_ready is all 0.
  - Adder evaluates the latched operands. The sum and overflow are registered into resp_data/resp_ovf/resp_id.
  - Go to RESP.
- State RESP:
  - resp_valid = 1. resp_data/resp_id/resp_ovf stay stable while resp_valid && !resp_ready.
  - On resp_ready: go to IDLE and clear resp_valid.
- Latency: acceptance edge E0 → resp_valid high after E1 (2 cycles). Minimum 3 cycles per op; no overlap.
- Arithmetic (sign-magnitude):
  - Equal signs: magnitudes are added; the result keeps the sign.
  - Differing signs: larger magnitude minus smaller; the result takes the larger's sign.
  - Equal magnitudes with differing signs give +0.
  - Negative zero is never emitted, from any path, including an input −0 + −0.
- Overflow: a carry out of the WIDTH-1 magnitude bits sets resp_ovf=1. The magnitude wraps modulo 2^(WIDTH-1) unless the optional feature is on.
- Requester behaviour: a requester dropping req_valid before acceptance is legal. Payload must be stable while req_valid is high.
- Starvation: a requester with valid held high is granted within NUM_REQ ops.

Optional Feature:
- Macro: FXP_ADD_ARB_SAT_EN.
- Defined: on overflow the magnitude saturates to all ones (sign preserved) and resp_ovf=1.
- Undefined: the magnitude wraps and resp_ovf=1.
- Sign handling and +0 canonicalization are identical in both builds.

Decomposition:
- Package fxp_arb_pkg holds:
  - state enum {IDLE, EXEC, RESP};
  - localparams SIGN_BIT = WIDTH-1 and MAG_W = WIDTH-1;
  - a function for the next round-robin pointer with wrap.
- One sub-module: fxp_sm_add_core, a combinational sign-magnitude adder with an added ovf output and zero canonicalization.
  - Parameterized by WIDTH.
  - Instantiated once in the arbiter.
  - Saturation is applied in the arbiter, not in the core.

Test Plan:
- Basic add: req 0 with a=0x0001_8000, b=0x8000_8000 → 2 cycles after acceptance resp_data=0x0001_0000, resp_id=0, resp_ovf=0.
- Cancel to zero: a=0x8000_4000, b=0x0000_4000 → resp_data=0x0000_0000. Also −0 + −0 (0x8000_0000 + 0x8000_0000) → 0x0000_0000.
- Overflow: a=b=0x7FFF_FFFF.
  - Without macro: resp_data=0x7FFF_FFFE, resp_ovf=1.
  - With FXP_ADD_ARB_SAT_EN: 0x7FFF_FFFF, resp_ovf=1.
- Round-robin: all 4 req_valid held high from reset → grant order 0,1,2,3,0. Starting with only req 2 valid, then all valid → order 2,3,0,1.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_data/resp_id stable, req_ready all 0; release → return to IDLE, next grant accepted.
- Reset mid-op: assert rst in EXEC → outputs 0 immediately, no response after release, ptr=0 so req 0 wins first.
